// File: rtl/mtimer_pkg.sv
// Shared definitions for the Wishbone machine timer: register indices and bit positions.
package mtimer_pkg;

    typedef enum logic [2:0] {
        MTIMER_MTIME_LO = 3'd0,
        MTIMER_MTIME_HI = 3'd1,
        MTIMER_CMP_LO   = 3'd2,
        MTIMER_CMP_HI   = 3'd3,
        MTIMER_CTRL     = 3'd4,
        MTIMER_PRESCALE = 3'd5,
        MTIMER_RSVD6    = 3'd6,
        MTIMER_RSVD7    = 3'd7
    } mtimer_reg_e;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int MTIP_BIT        = 7;

endpackage

// File: rtl/wb_slave_if.sv
// Single-beat pipelined Wishbone slave front end: accept, one-stage ack with abort, byte-masked write merge.
module wb_slave_if (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] old_word,
    input  logic [31:0] rd_word,
    output logic        accept,
    output logic        wr_en,
    output logic [31:0] wr_word
);

    logic [1:0]  vld_pipe;
    logic [31:0] dat_q;

    assign accept      = wb_cyc_i & wb_stb_i;
    assign vld_pipe[0] = accept;
    assign wr_en       = accept & wb_we_i & (|wb_sel_i);
    assign wb_stall_o  = 1'b0;

    for (genvar b = 0; b < 4; b++) begin : g_merge
        assign wr_word[8*b +: 8] = wb_sel_i[b] ? wb_dat_i[8*b +: 8] : old_word[8*b +: 8];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe[1] <= 1'b0;
            dat_q       <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0] & wb_cyc_i;
            dat_q       <= accept ? rd_word : '0;
        end
    end

    // A master that drops cyc abandons its pending ack.
    assign wb_ack_o = vld_pipe[1] & wb_cyc_i;
    assign wb_dat_o = dat_q;

endmodule

// File: rtl/wb_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp with prescaler) on a pipelined Wishbone slave port.
module wb_mtimer
    import mtimer_pkg::*;
#(
    parameter logic [31:0] PRESCALE_RESET = 32'd0,
    parameter logic [63:0] CMP_RESET      = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        irq_o
);

    mtimer_reg_e idx;
    logic [63:0] mtime, mtimecmp;
    logic [31:0] prescale, pcnt, hi_shadow;
    logic        en, irq_en, irq_q;
    logic        accept, wr_en, tick;
    logic [31:0] old_word, rd_word, wr_word;
    logic        unused_adr;

    assign idx        = mtimer_reg_e'(wb_adr_i[4:2]);
    assign unused_adr = &{1'b0, wb_adr_i[31:5], wb_adr_i[1:0]};

    wb_slave_if u_wb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_i   (wb_dat_i),
        .wb_stall_o (wb_stall_o),
        .wb_ack_o   (wb_ack_o),
        .wb_dat_o   (wb_dat_o),
        .old_word   (old_word),
        .rd_word    (rd_word),
        .accept     (accept),
        .wr_en      (wr_en),
        .wr_word    (wr_word)
    );

    // old_word feeds the byte merge (live values); rd_word is what the bus sees (HI via shadow).
    always_comb begin
        old_word = '0;
        case (idx)
            MTIMER_MTIME_LO: old_word = mtime[31:0];
            MTIMER_MTIME_HI: old_word = mtime[63:32];
            MTIMER_CMP_LO:   old_word = mtimecmp[31:0];
            MTIMER_CMP_HI:   old_word = mtimecmp[63:32];
            MTIMER_CTRL:     old_word = {30'd0, irq_en, en};
            MTIMER_PRESCALE: old_word = prescale;
            default:         old_word = '0;
        endcase
        rd_word = (idx == MTIMER_MTIME_HI) ? hi_shadow : old_word;
    end

    assign tick = en & (pcnt == prescale);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime     <= '0;
            mtimecmp  <= CMP_RESET;
            prescale  <= PRESCALE_RESET;
            pcnt      <= '0;
            hi_shadow <= '0;
            en        <= 1'b0;
            irq_en    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (accept && !wb_we_i && idx == MTIMER_MTIME_LO)
                hi_shadow <= mtime[63:32];

            if (wr_en && (idx == MTIMER_PRESCALE || idx == MTIMER_CTRL))
                pcnt <= '0;
            else if (en)
                pcnt <= tick ? '0 : pcnt + 32'd1;

            // A software write to either half wins over the tick; no carry across halves.
            if (wr_en && idx == MTIMER_MTIME_LO)
                mtime[31:0] <= wr_word;
            else if (wr_en && idx == MTIMER_MTIME_HI)
                mtime[63:32] <= wr_word;
            else if (tick)
                mtime <= mtime + 64'd1;

            if (wr_en && idx == MTIMER_CMP_LO) mtimecmp[31:0]  <= wr_word;
            if (wr_en && idx == MTIMER_CMP_HI) mtimecmp[63:32] <= wr_word;
            if (wr_en && idx == MTIMER_PRESCALE) prescale <= wr_word;
            if (wr_en && idx == MTIMER_CTRL) begin
                en     <= wr_word[CTRL_EN_BIT];
                irq_en <= wr_word[CTRL_IRQ_EN_BIT];
            end

            irq_q <= irq_en & (mtime >= mtimecmp);
        end
    end

    assign irq_o = irq_q;

endmodule
